sp_sweep_sequencer: RTL and testbench

- Digital controller for an N-port S-parameter measurement run on a biased balun/filter DUT.
- Sequence:
  - Enables DC bias once and waits for it to settle.
  - Steps through NPTS frequency indices.
  - At each index, excites each port in turn, one-hot, and emits one measurement strobe per (frequency, port) pair through a valid/ready handshake.
- Sits between the run-control register block and the receiver/ADC capture path.

---
 rtl/sp_seq_pkg.sv | 34 +++
 rtl/sp_sweep_sequencer_dwell.sv | 23 ++
 rtl/sp_sweep_sequencer.sv | 133 +++++++++++++
 tb/tb_sp_sweep_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_seq_pkg.sv
// Shared types and elaboration-time helpers for the S-parameter sweep sequencer.
package sp_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_TUNE,
        S_MEAS,
        S_EMIT,
        S_DONE
    } state_e;

    // ceil(log2(v)), but never less than 1 so a 1-entry index still has a bit
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Width of the shared dwell counter: must hold the largest dwell value
    function automatic int unsigned dwell_w(input int unsigned b,
                                            input int unsigned t,
                                            input int unsigned m);
        int unsigned mx;
        mx = b;
        if (t > mx) mx = t;
        if (m > mx) mx = m;
        return clog2_min1(mx + 1);
    endfunction

endpackage

// File: rtl/sp_sweep_sequencer_dwell.sv
// Loadable down-counter; expired while the count sits at zero.
module dwell_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    // Load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               cnt_q <= '0;
        else if (load)         cnt_q <= load_val;
        else if (cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/sp_sweep_sequencer.sv
// Bias / retune / excite / emit sequencer for an N-port S-parameter sweep.
module sp_sweep_sequencer
    import sp_seq_pkg::*;
#(
    parameter  int unsigned NPORTS   = 2,
    parameter  int unsigned NPTS     = 201,
    parameter  int unsigned BIAS_W   = 12,
    parameter  int unsigned BIAS_CYC = 64,
    parameter  int unsigned TUNE_CYC = 8,
    parameter  int unsigned MEAS_CYC = 16,
    localparam int unsigned FIDX_W   = clog2_min1(NPTS),
    localparam int unsigned PIDX_W   = clog2_min1(NPORTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [BIAS_W-1:0] bias_code_in,
    output logic [BIAS_W-1:0] bias_code,
    output logic              bias_en,
    output logic [NPORTS-1:0] exc_en,
    output logic [FIDX_W-1:0] freq_idx,
    output logic              meas_valid,
    input  logic              meas_ready,
    output logic [FIDX_W-1:0] meas_fidx,
    output logic [PIDX_W-1:0] meas_port,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int unsigned DWELL_W = dwell_w(BIAS_CYC, TUNE_CYC, MEAS_CYC);

    state_e             state_q, state_d;
    logic [FIDX_W-1:0]  fidx_q, fidx_d;
    logic [PIDX_W-1:0]  port_q, port_d;
    logic [BIAS_W-1:0]  bias_q, bias_d;
    logic               aborted_q, aborted_d;
    logic               tmr_load;
    logic [DWELL_W-1:0] tmr_val;
    logic               tmr_exp;

    dwell_timer #(.W(DWELL_W)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    // State, counters, captured bias code and abort pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            fidx_q    <= '0;
            port_q    <= '0;
            bias_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fidx_q    <= fidx_d;
            port_q    <= port_d;
            bias_q    <= bias_d;
            aborted_q <= aborted_d;
        end
    end

    // Next-state, counter update and dwell reload on entry to a timed state
    always_comb begin
        state_d   = state_q;
        fidx_d    = fidx_q;
        port_d    = port_q;
        bias_d    = bias_q;
        aborted_d = 1'b0;
        if (state_q != S_IDLE && abort) begin
            state_d   = S_IDLE;
            fidx_d    = '0;
            port_d    = '0;
            aborted_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: if (start && !abort) begin
                    bias_d  = bias_code_in;
                    state_d = S_BIAS;
                end
                S_BIAS: if (tmr_exp) state_d = S_TUNE;
                S_TUNE: if (tmr_exp) state_d = S_MEAS;
                S_MEAS: if (tmr_exp) state_d = S_EMIT;
                S_EMIT: if (meas_ready) begin
                    if (port_q < PIDX_W'(NPORTS - 1)) begin
                        port_d  = port_q + 1'b1;
                        state_d = S_MEAS;
                    end else if (fidx_q < FIDX_W'(NPTS - 1)) begin
                        fidx_d  = fidx_q + 1'b1;
                        port_d  = '0;
                        state_d = S_TUNE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    fidx_d  = '0;
                    port_d  = '0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        tmr_load = (state_d != state_q) &&
                   (state_d == S_BIAS || state_d == S_TUNE || state_d == S_MEAS);
        unique case (state_d)
            S_BIAS:  tmr_val = DWELL_W'(BIAS_CYC - 1);
            S_TUNE:  tmr_val = DWELL_W'(TUNE_CYC - 1);
            default: tmr_val = DWELL_W'(MEAS_CYC - 1);
        endcase
    end

    // Moore outputs decoded from the registered state
    assign bias_code  = bias_q;
    assign bias_en    = (state_q == S_BIAS) || (state_q == S_TUNE) ||
                        (state_q == S_MEAS) || (state_q == S_EMIT);
    assign exc_en     = (state_q == S_MEAS || state_q == S_EMIT) ?
                        (NPORTS'(1) << port_q) : '0;
    assign freq_idx   = fidx_q;
    assign meas_valid = (state_q == S_EMIT);
    assign meas_fidx  = (state_q == S_EMIT) ? fidx_q : '0;
    assign meas_port  = (state_q == S_EMIT) ? port_q : '0;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign aborted    = aborted_q;

endmodule

// File: tb/tb_sp_sweep_sequencer.sv
// Scoreboard bench for sp_sweep_sequencer (NPORTS=2, NPTS=3, dwells 4/2/3).
module tb_sp_sweep_sequencer;

    localparam int unsigned NPORTS = 2;
    localparam int unsigned NPTS   = 3;
    localparam int unsigned BIAS_W = 12;
    localparam int unsigned FIDX_W = 2;
    localparam int unsigned PIDX_W = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              meas_ready = 1'b1;
    logic [BIAS_W-1:0] bias_code_in = '0;
    logic [BIAS_W-1:0] bias_code;
    logic              bias_en, meas_valid, busy, done, aborted;
    logic [NPORTS-1:0] exc_en;
    logic [FIDX_W-1:0] freq_idx, meas_fidx;
    logic [PIDX_W-1:0] meas_port;

    sp_sweep_sequencer #(
        .NPORTS   (NPORTS),
        .NPTS     (NPTS),
        .BIAS_W   (BIAS_W),
        .BIAS_CYC (4),
        .TUNE_CYC (2),
        .MEAS_CYC (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .bias_code_in (bias_code_in),
        .bias_code    (bias_code),
        .bias_en      (bias_en),
        .exc_en       (exc_en),
        .freq_idx     (freq_idx),
        .meas_valid   (meas_valid),
        .meas_ready   (meas_ready),
        .meas_fidx    (meas_fidx),
        .meas_port    (meas_port),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted)
    );

    // kind: 0 = measurement transfer, 1 = done pulse, 2 = aborted pulse
    typedef struct {
        int kind;
        int cyc;
        int fidx;
        int port;
    } ev_t;

    ev_t               sb[$];
    int                vectors = 0;
    int                miscompares = 0;
    int                cyc = 0;
    int                c0 = 0;
    logic [BIAS_W-1:0] exp_bias = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (rel cycle %0d)", nm, act, req, cyc - c0);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rel(input int n);
        while (cyc - c0 < n) step(1);
    endtask

    // Expected events of a full sweep; shift delays every transfer (stalled first EMIT)
    task automatic push_run(input int shift);
        int mc[6];
        mc = '{10, 14, 20, 24, 30, 34};
        for (int i = 0; i < 6; i++)
            sb.push_back('{0, mc[i] + shift, i / 2, i % 2});
        sb.push_back('{1, 35 + shift, 0, 0});
    endtask

    // Called at posedge+1; this cycle becomes relative cycle 0
    task automatic start_sweep(input logic [BIAS_W-1:0] b);
        c0           = cyc;
        exp_bias     = b;
        bias_code_in = b;
        start        = 1'b1;
        step(1);
        start        = 1'b0;
        bias_code_in = BIAS_W'($urandom);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on every output event
    logic              stall_q = 1'b0;
    logic [FIDX_W-1:0] sv_fidx;
    logic [PIDX_W-1:0] sv_port;
    logic [NPORTS-1:0] sv_exc;
    ev_t               e;
    int                kind;

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            chk("exc_onehot", 32'($countones(exc_en) <= 1), 32'd1);
            if (busy) chk("bias_code", 32'(bias_code), 32'(exp_bias));
            if (meas_valid && stall_q) begin
                chk("hold_fidx", 32'(meas_fidx), 32'(sv_fidx));
                chk("hold_port", 32'(meas_port), 32'(sv_port));
                chk("hold_exc",  32'(exc_en),    32'(sv_exc));
            end
            if (meas_valid && !meas_ready) begin
                stall_q = 1'b1;
                sv_fidx = meas_fidx;
                sv_port = meas_port;
                sv_exc  = exc_en;
            end else begin
                stall_q = 1'b0;
            end
            if ((meas_valid && meas_ready) || done || aborted) begin
                kind = (meas_valid && meas_ready) ? 0 : (done ? 1 : 2);
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_event: got kind %0d at rel cycle %0d, required none",
                             kind, cyc - c0);
                end else begin
                    e = sb.pop_front();
                    chk("ev_kind",  32'(kind),      32'(e.kind));
                    chk("ev_cycle", 32'(cyc - c0),  32'(e.cyc));
                    if (e.kind == 0) begin
                        chk("meas_fidx", 32'(meas_fidx), 32'(e.fidx));
                        chk("meas_port", 32'(meas_port), 32'(e.port));
                        chk("freq_idx",  32'(freq_idx),  32'(e.fidx));
                        chk("exc_en",    32'(exc_en),    32'd1 << e.port);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset: every output low
        #1 rst = 1'b1;
        #2;
        chk("rst_bias_code", 32'(bias_code), 32'd0);
        chk("rst_bias_en",   32'(bias_en),   32'd0);
        chk("rst_exc_en",    32'(exc_en),    32'd0);
        chk("rst_freq_idx",  32'(freq_idx),  32'd0);
        chk("rst_valid",     32'(meas_valid),32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_aborted",   32'(aborted),   32'd0);
        step(2);
        rst = 1'b0;
        step(2);

        // 1: nominal sweep, ready tied high
        push_run(0);
        start_sweep(12'h5A3);
        wait_rel(35);
        chk("t1_busy_done_cyc", 32'(busy), 32'd1);
        wait_rel(36);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_fidx_clear", 32'(freq_idx), 32'd0);
        step(2);

        // 2: first EMIT stalled for 5 cycles
        meas_ready = 1'b0;
        push_run(5);
        start_sweep(12'h0F1);
        wait_rel(9);
        chk("t2_valid_c9",  32'(meas_valid), 32'd0);
        wait_rel(10);
        chk("t2_valid_c10", 32'(meas_valid), 32'd1);
        wait_rel(15);
        chk("t2_valid_c15", 32'(meas_valid), 32'd1);
        meas_ready = 1'b1;
        wait_rel(41);
        chk("t2_busy_after", 32'(busy), 32'd0);
        step(2);

        // 3: abort in MEAS port 1, then a fresh sweep
        sb.push_back('{0, 10, 0, 0});
        sb.push_back('{2, 13, 0, 0});
        start_sweep(12'hABC);
        wait_rel(12);
        chk("t3_port1_exc", 32'(exc_en), 32'd2);
        abort = 1'b1;
        wait_rel(13);
        abort = 1'b0;
        chk("t3_aborted", 32'(aborted), 32'd1);
        chk("t3_busy",    32'(busy),    32'd0);
        chk("t3_bias_en", 32'(bias_en), 32'd0);
        chk("t3_exc_en",  32'(exc_en),  32'd0);
        wait_rel(20);
        push_run(0);
        start_sweep(12'h321);
        wait_rel(36);
        chk("t3_busy_after", 32'(busy), 32'd0);
        step(2);

        // 4: start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        step(1);
        start = 1'b0;
        abort = 1'b0;
        chk("t4_busy",    32'(busy),    32'd0);
        chk("t4_aborted", 32'(aborted), 32'd0);
        step(1);
        chk("t4_busy2",   32'(busy),    32'd0);
        step(2);

        // 5: second start mid-sweep is ignored
        push_run(0);
        start_sweep(12'h777);
        wait_rel(6);
        start        = 1'b1;
        bias_code_in = 12'h111;
        step(1);
        start        = 1'b0;
        wait_rel(36);
        chk("t5_busy_after", 32'(busy), 32'd0);
        step(2);

        // 6: async reset while stalled in EMIT
        meas_ready = 1'b0;
        start_sweep(12'h9E4);
        wait_rel(12);
        chk("t6_in_emit", 32'(meas_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        sb.delete();
        chk("t6_bias_code", 32'(bias_code), 32'd0);
        chk("t6_bias_en",   32'(bias_en),   32'd0);
        chk("t6_exc_en",    32'(exc_en),    32'd0);
        chk("t6_valid",     32'(meas_valid),32'd0);
        chk("t6_mfidx",     32'(meas_fidx), 32'd0);
        chk("t6_busy",      32'(busy),      32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        meas_ready = 1'b1;
        step(2);
        chk("t6_idle_busy", 32'(busy),     32'd0);
        chk("t6_idle_fidx", 32'(freq_idx), 32'd0);
        push_run(0);
        start_sweep(12'h246);
        wait_rel(36);
        chk("t6_busy_after", 32'(busy), 32'd0);
        step(2);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
